// File: rtl/stark_checkpoint_pool.sv
// Checkpoint free-list for the rename stage.
// One 1x core cycle spans five clk5x edges, marked by the one-hot ph4:
//   ph4[0]    : allocate from the published list and latch all free requests
//   ph4[1..4] : apply the latched frees of lane 0..3, one lane per edge
//   ph4[4]    : additionally publish the four lowest free indices, count and stall
// Handshake: an allocate request (alloc_chkpt, or br[k] in per-lane mode) is
// accepted at the ph4[0] edge only while stall is low. A request seen while
// stall is high is dropped, and the requester keeps it asserted until a later
// cycle accepts it. Frees have no back-pressure and are always accepted.
module stark_checkpoint_pool #(
    parameter int NCHKPT      = 16,
    parameter int GROUP_ALLOC = 1,
    localparam int CB         = $clog2(NCHKPT)
) (
    input  logic                 clk5x,
    input  logic                 rst,
    input  logic [4:0]           ph4,
    input  logic                 alloc_chkpt,
    input  logic [3:0]           br,
    input  logic [3:0]           free_chkpt_i,
    input  logic [3:0][CB-1:0]   fchkpt_i,
    input  logic [3:0]           free_chkpt2,
    input  logic [3:0][CB-1:0]   fchkpt2,
    output logic [3:0][CB-1:0]   chkptn,
    output logic                 stall,
    output logic [CB:0]          free_count,
    output logic                 err_dblfree
);

    // Minimum number of free checkpoints needed to accept one allocation request.
    localparam logic [CB:0] NEED = (GROUP_ALLOC != 0) ? (CB+1)'(1) : (CB+1)'(4);

    logic [NCHKPT-1:0]   busy;
    logic [3:0]          lat_fv1;
    logic [3:0]          lat_fv2;
    logic [3:0][CB-1:0]  lat_fi1;
    logic [3:0][CB-1:0]  lat_fi2;

    logic [NCHKPT-1:0]   busy_alloc;
    logic [NCHKPT-1:0]   busy_free;
    logic                dbl;
    logic [1:0]          lane;
    logic                lane_act;
    logic                v1;
    logic                v2;
    logic [CB-1:0]       f1;
    logic [CB-1:0]       f2;
    logic [3:0][CB-1:0]  pub_chk;
    logic [CB:0]         pub_cnt;
    logic [2:0]          found;
    logic                pub_stall;

    // Only one of the two request styles is used for a given GROUP_ALLOC.
    logic unused_req;
    assign unused_req = ^{br, alloc_chkpt};

    // Decode which latched lane the current free sub-phase works on.
    always_comb begin
        lane_act = |ph4[4:1];
        lane     = 2'd0;
        if (ph4[2]) lane = 2'd1;
        if (ph4[3]) lane = 2'd2;
        if (ph4[4]) lane = 2'd3;
    end

    // Allocation: mark the published indices busy for each accepted request.
    always_comb begin
        busy_alloc = busy;
        if (!stall) begin
            if (GROUP_ALLOC != 0) begin
                if (alloc_chkpt) busy_alloc[chkptn[0]] = 1'b1;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (br[k]) busy_alloc[chkptn[k]] = 1'b1;
                end
            end
        end
    end

    // Free one lane: branch-done first, then backout; same index is cleared once.
    always_comb begin
        busy_free = busy;
        dbl       = 1'b0;
        f1        = lat_fi1[lane];
        f2        = lat_fi2[lane];
        v1        = lat_fv1[lane];
        v2        = lat_fv2[lane] && !(lat_fv1[lane] && (f2 == f1));
        if (v1) begin
            if (busy[f1]) busy_free[f1] = 1'b0;
            else          dbl           = 1'b1;
        end
        if (v2) begin
            if (busy[f2]) busy_free[f2] = 1'b0;
            else          dbl           = 1'b1;
        end
    end

    // Publish view computed from the bitmap after this edge's lane is applied.
    always_comb begin
        pub_chk = '0;
        pub_cnt = '0;
        found   = 3'd0;
        for (int i = 0; i < NCHKPT; i++) begin
            if (!busy_free[i]) begin
                pub_cnt = pub_cnt + 1'b1;
                if (found < 3'd4) begin
                    pub_chk[found[1:0]] = i[CB-1:0];
                    found               = found + 3'd1;
                end
            end
        end
        // Unfilled slots repeat the last valid index (all zero when none are free).
        if (found < 3'd2) pub_chk[1] = pub_chk[0];
        if (found < 3'd3) pub_chk[2] = pub_chk[1];
        if (found < 3'd4) pub_chk[3] = pub_chk[2];
        pub_stall = (pub_cnt < NEED);
    end

    // Bitmap, request latches and registered outputs, sequenced by ph4.
    always_ff @(posedge clk5x) begin
        if (rst) begin
            busy        <= {{(NCHKPT-1){1'b0}}, 1'b1};
            lat_fv1     <= '0;
            lat_fv2     <= '0;
            lat_fi1     <= '0;
            lat_fi2     <= '0;
            for (int j = 0; j < 4; j++) chkptn[j] <= CB'(j + 1);
            stall       <= 1'b0;
            free_count  <= (CB+1)'(NCHKPT - 1);
            err_dblfree <= 1'b0;
        end else if (ph4[0]) begin
            busy    <= busy_alloc;
            lat_fv1 <= free_chkpt_i;
            lat_fi1 <= fchkpt_i;
            lat_fv2 <= free_chkpt2;
            lat_fi2 <= fchkpt2;
        end else if (lane_act) begin
            busy <= busy_free;
            if (dbl) err_dblfree <= 1'b1;
            if (ph4[4]) begin
                chkptn     <= pub_chk;
                free_count <= pub_cnt;
                stall      <= pub_stall;
            end
        end
    end

endmodule

// File: tb/tb_stark_checkpoint_pool.sv
// Bench for stark_checkpoint_pool: instance 0 in group mode, instance 1 in
// per-lane mode, both checked against a set/queue based free-list model.
module tb_stark_checkpoint_pool;

    localparam int NCHKPT = 16;
    localparam int CB     = 4;

    // ---------------- clock / reset ----------------
    logic clk5x = 1'b0;
    always #5 clk5x = ~clk5x;

    logic [4:0]          ph4;
    logic                rst_s [2];
    logic                alloc_a;
    logic                alloc_idle;
    logic [3:0]          br_b;
    logic [3:0]          br_idle;
    logic [3:0]          fv1 [2];
    logic [3:0][CB-1:0]  fi1 [2];
    logic [3:0]          fv2 [2];
    logic [3:0][CB-1:0]  fi2 [2];
    logic [3:0][CB-1:0]  o_chk [2];
    logic                o_stall [2];
    logic [CB:0]         o_cnt [2];
    logic                o_err [2];

    stark_checkpoint_pool #(.NCHKPT(NCHKPT), .GROUP_ALLOC(1)) u_grp (
        .clk5x(clk5x), .rst(rst_s[0]), .ph4(ph4),
        .alloc_chkpt(alloc_a), .br(br_idle),
        .free_chkpt_i(fv1[0]), .fchkpt_i(fi1[0]),
        .free_chkpt2(fv2[0]), .fchkpt2(fi2[0]),
        .chkptn(o_chk[0]), .stall(o_stall[0]),
        .free_count(o_cnt[0]), .err_dblfree(o_err[0])
    );

    stark_checkpoint_pool #(.NCHKPT(NCHKPT), .GROUP_ALLOC(0)) u_lane (
        .clk5x(clk5x), .rst(rst_s[1]), .ph4(ph4),
        .alloc_chkpt(alloc_idle), .br(br_b),
        .free_chkpt_i(fv1[1]), .fchkpt_i(fi1[1]),
        .free_chkpt2(fv2[1]), .fchkpt2(fi2[1]),
        .chkptn(o_chk[1]), .stall(o_stall[1]),
        .free_count(o_cnt[1]), .err_dblfree(o_err[1])
    );

    always @(posedge clk5x) begin
        assert ($onehot0(ph4)) else $error("ph4 has more than one bit set: %b", ph4);
    end

    int n_chk  = 0;
    int n_fail = 0;

    // ---------------- reference model ----------------
    bit m_busy [2][NCHKPT];
    int m_pub  [2][4];
    int m_cnt  [2];
    bit m_stall[2];
    bit m_err  [2];
    bit ml_v1  [2][4];
    bit ml_v2  [2][4];
    int ml_i1  [2][4];
    int ml_i2  [2][4];

    task automatic model_reset(input int d);
        for (int i = 0; i < NCHKPT; i++) m_busy[d][i] = (i == 0);
        for (int j = 0; j < 4; j++) begin
            m_pub[d][j] = j + 1;
            ml_v1[d][j] = 0;
            ml_v2[d][j] = 0;
        end
        m_cnt[d]   = NCHKPT - 1;
        m_stall[d] = 0;
        m_err[d]   = 0;
    endtask

    task automatic model_publish(input int d);
        int q[$];
        for (int i = 0; i < NCHKPT; i++) if (!m_busy[d][i]) q.push_back(i);
        m_cnt[d] = q.size();
        for (int j = 0; j < 4; j++)
            m_pub[d][j] = (j < q.size()) ? q[j] : ((q.size() > 0) ? q[q.size()-1] : 0);
        m_stall[d] = (m_cnt[d] < ((d == 0) ? 1 : 4));
    endtask

    task automatic model_free(input int d, input int idx);
        if (m_busy[d][idx]) m_busy[d][idx] = 0;
        else                m_err[d]       = 1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_requests();
        alloc_a = 0;
        br_b    = '0;
        for (int d = 0; d < 2; d++) begin
            fv1[d] = '0; fi1[d] = '0; fv2[d] = '0; fi2[d] = '0;
        end
    endtask

    // One clk5x edge with ph4 = 1<<p (p<0 means all-zero ph4); model updated alongside.
    task automatic step_phase(input int p);
        ph4 = (p < 0) ? 5'b00000 : 5'(1 << p);
        for (int d = 0; d < 2; d++) begin
            if (rst_s[d]) model_reset(d);
            else if (p == 0) begin
                if (!m_stall[d]) begin
                    if (d == 0) begin
                        if (alloc_a) m_busy[0][m_pub[0][0]] = 1;
                    end else begin
                        for (int k = 0; k < 4; k++) if (br_b[k]) m_busy[1][m_pub[1][k]] = 1;
                    end
                end
                for (int k = 0; k < 4; k++) begin
                    ml_v1[d][k] = fv1[d][k]; ml_i1[d][k] = int'(fi1[d][k]);
                    ml_v2[d][k] = fv2[d][k]; ml_i2[d][k] = int'(fi2[d][k]);
                end
            end else if (p >= 1) begin
                if (ml_v1[d][p-1]) model_free(d, ml_i1[d][p-1]);
                if (ml_v2[d][p-1] && !(ml_v1[d][p-1] && ml_i1[d][p-1] == ml_i2[d][p-1]))
                    model_free(d, ml_i2[d][p-1]);
                if (p == 4) model_publish(d);
            end
        end
        @(posedge clk5x);
        #1;
        if (p == 0) clear_requests();
    endtask

    task automatic run_cycle();
        for (int p = 0; p < 5; p++) step_phase(p);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_s[0] = 1; rst_s[1] = 1;
        step_phase(-1); step_phase(-1);
        rst_s[0] = 0; rst_s[1] = 0;
        run_cycle();
        for (int d = 0; d < 2; d++) begin
            for (int j = 0; j < 4; j++) begin
                n_chk++;
                if (o_chk[d][j] !== CB'(j + 1)) begin
                    n_fail++; $display("FAIL reset_chkptn d=%0d j=%0d got=%0d exp=%0d", d, j, o_chk[d][j], j + 1);
                end
            end
            n_chk++;
            if (o_cnt[d] !== 5'd15) begin n_fail++; $display("FAIL reset_count d=%0d got=%0d exp=15", d, o_cnt[d]); end
            n_chk++;
            if (o_stall[d] !== 1'b0) begin n_fail++; $display("FAIL reset_stall d=%0d got=%b exp=0", d, o_stall[d]); end
            n_chk++;
            if (o_err[d] !== 1'b0) begin n_fail++; $display("FAIL reset_err d=%0d got=%b exp=0", d, o_err[d]); end
        end
    endtask

    task automatic test_group_fill();
        for (int c = 0; c < 15; c++) begin
            n_chk++;
            if (o_chk[0][0] !== CB'(c + 1)) begin
                n_fail++; $display("FAIL alloc_order c=%0d got=%0d exp=%0d", c, o_chk[0][0], c + 1);
            end
            alloc_a = 1;
            run_cycle();
            n_chk++;
            if (o_cnt[0] !== 5'(14 - c)) begin
                n_fail++; $display("FAIL fill_count c=%0d got=%0d exp=%0d", c, o_cnt[0], 14 - c);
            end
        end
        n_chk++;
        if (o_stall[0] !== 1'b1) begin n_fail++; $display("FAIL full_stall got=%b exp=1", o_stall[0]); end
        alloc_a = 1;
        run_cycle();
        n_chk++;
        if (o_cnt[0] !== 5'd0) begin n_fail++; $display("FAIL dropped_alloc_count got=%0d exp=0", o_cnt[0]); end
        n_chk++;
        if (o_stall[0] !== 1'b1) begin n_fail++; $display("FAIL dropped_alloc_stall got=%b exp=1", o_stall[0]); end
        for (int j = 0; j < 4; j++) begin
            n_chk++;
            if (o_chk[0][j] !== CB'(m_pub[0][j])) begin
                n_fail++; $display("FAIL full_chkptn j=%0d got=%0d exp=%0d", j, o_chk[0][j], m_pub[0][j]);
            end
        end
    endtask

    task automatic test_free_pair_hold();
        int exp_chk[4] = '{3, 7, 7, 7};
        fv1[0] = 4'b0101;
        fi1[0][0] = 4'd7;
        fi1[0][2] = 4'd3;
        for (int p = 0; p < 4; p++) begin
            step_phase(p);
            n_chk++;
            if (o_cnt[0] !== 5'd0 || o_stall[0] !== 1'b1) begin
                n_fail++; $display("FAIL hold_mid_cycle p=%0d count=%0d stall=%b exp 0/1", p, o_cnt[0], o_stall[0]);
            end
        end
        step_phase(4);
        n_chk++;
        if (o_cnt[0] !== 5'd2) begin n_fail++; $display("FAIL free_pair_count got=%0d exp=2", o_cnt[0]); end
        n_chk++;
        if (o_stall[0] !== 1'b0) begin n_fail++; $display("FAIL free_pair_stall got=%b exp=0", o_stall[0]); end
        for (int j = 0; j < 4; j++) begin
            n_chk++;
            if (o_chk[0][j] !== CB'(exp_chk[j])) begin
                n_fail++; $display("FAIL free_pair_chkptn j=%0d got=%0d exp=%0d", j, o_chk[0][j], exp_chk[j]);
            end
        end
        for (int e = 0; e < 3; e++) step_phase(-1);
        n_chk++;
        if (o_cnt[0] !== 5'd2 || o_chk[0][0] !== 4'd3) begin
            n_fail++; $display("FAIL idle_hold count=%0d chk0=%0d exp 2/3", o_cnt[0], o_chk[0][0]);
        end
    endtask

    task automatic test_alloc_free_same();
        alloc_a   = 1;
        fv2[0]    = 4'b0001;
        fi2[0][0] = 4'd3;
        run_cycle();
        n_chk++;
        if (o_cnt[0] !== 5'd2) begin n_fail++; $display("FAIL same_cycle_count got=%0d exp=2", o_cnt[0]); end
        n_chk++;
        if (o_chk[0][0] !== 4'd3) begin n_fail++; $display("FAIL same_cycle_chk0 got=%0d exp=3", o_chk[0][0]); end
        n_chk++;
        if (o_err[0] !== 1'b0) begin n_fail++; $display("FAIL same_cycle_err got=%b exp=0", o_err[0]); end
    endtask

    task automatic test_both_same_index();
        int exp_chk[4] = '{3, 7, 9, 9};
        fv1[0] = 4'b1000; fi1[0][3] = 4'd9;
        fv2[0] = 4'b1000; fi2[0][3] = 4'd9;
        run_cycle();
        n_chk++;
        if (o_cnt[0] !== 5'd3) begin n_fail++; $display("FAIL dual_same_count got=%0d exp=3", o_cnt[0]); end
        n_chk++;
        if (o_err[0] !== 1'b0) begin n_fail++; $display("FAIL dual_same_err got=%b exp=0", o_err[0]); end
        for (int j = 0; j < 4; j++) begin
            n_chk++;
            if (o_chk[0][j] !== CB'(exp_chk[j])) begin
                n_fail++; $display("FAIL dual_same_chkptn j=%0d got=%0d exp=%0d", j, o_chk[0][j], exp_chk[j]);
            end
        end
    endtask

    task automatic test_dblfree();
        for (int t = 0; t < 2; t++) begin
            fv1[0] = 4'b0010; fi1[0][1] = 4'd5;
            run_cycle();
            n_chk++;
            if (o_cnt[0] !== 5'd4) begin n_fail++; $display("FAIL dblfree_count t=%0d got=%0d exp=4", t, o_cnt[0]); end
            n_chk++;
            if (o_err[0] !== 1'(t)) begin n_fail++; $display("FAIL dblfree_err t=%0d got=%b exp=%0d", t, o_err[0], t); end
        end
        run_cycle(); run_cycle();
        n_chk++;
        if (o_err[0] !== 1'b1) begin n_fail++; $display("FAIL dblfree_sticky got=%b exp=1", o_err[0]); end
        n_chk++;
        if (o_chk[0][1] !== 4'd5) begin n_fail++; $display("FAIL dblfree_chk1 got=%0d exp=5", o_chk[0][1]); end
    endtask

    task automatic test_random(input int d, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            if (d == 0) alloc_a = 1'($urandom_range(0, 1));
            else        br_b    = 4'($urandom_range(0, 15));
            for (int k = 0; k < 4; k++) begin
                fv1[d][k] = ($urandom_range(0, 3) == 0);
                fi1[d][k] = CB'($urandom_range(0, NCHKPT - 1));
                fv2[d][k] = ($urandom_range(0, 5) == 0);
                fi2[d][k] = CB'($urandom_range(0, NCHKPT - 1));
            end
            run_cycle();
            for (int j = 0; j < 4; j++) begin
                n_chk++;
                if (o_chk[d][j] !== CB'(m_pub[d][j])) begin
                    n_fail++; $display("FAIL rand_chkptn d=%0d c=%0d j=%0d got=%0d exp=%0d", d, c, j, o_chk[d][j], m_pub[d][j]);
                end
            end
            n_chk++;
            if (o_cnt[d] !== 5'(m_cnt[d]) || o_stall[d] !== m_stall[d] || o_err[d] !== m_err[d]) begin
                n_fail++;
                $display("FAIL rand_status d=%0d c=%0d got cnt=%0d stall=%b err=%b exp cnt=%0d stall=%b err=%b",
                         d, c, o_cnt[d], o_stall[d], o_err[d], m_cnt[d], m_stall[d], m_err[d]);
            end
        end
    endtask

    task automatic test_lane_alloc();
        int exp_chk[4] = '{11, 12, 13, 14};
        rst_s[1] = 1;
        run_cycle();
        rst_s[1] = 0;
        run_cycle();
        n_chk++;
        if (o_cnt[1] !== 5'd15) begin n_fail++; $display("FAIL lane_reset_count got=%0d exp=15", o_cnt[1]); end
        br_b = 4'b1111; run_cycle();
        br_b = 4'b1111; run_cycle();
        br_b = 4'b0011; run_cycle();
        n_chk++;
        if (o_cnt[1] !== 5'd5 || o_stall[1] !== 1'b0) begin
            n_fail++; $display("FAIL lane_five_free count=%0d stall=%b exp 5/0", o_cnt[1], o_stall[1]);
        end
        for (int j = 0; j < 4; j++) begin
            n_chk++;
            if (o_chk[1][j] !== CB'(exp_chk[j])) begin
                n_fail++; $display("FAIL lane_five_chkptn j=%0d got=%0d exp=%0d", j, o_chk[1][j], exp_chk[j]);
            end
        end
        br_b = 4'b1111; run_cycle();
        n_chk++;
        if (o_cnt[1] !== 5'd1 || o_stall[1] !== 1'b1) begin
            n_fail++; $display("FAIL lane_one_free count=%0d stall=%b exp 1/1", o_cnt[1], o_stall[1]);
        end
        for (int j = 0; j < 4; j++) begin
            n_chk++;
            if (o_chk[1][j] !== 4'd15) begin
                n_fail++; $display("FAIL lane_one_chkptn j=%0d got=%0d exp=15", j, o_chk[1][j]);
            end
        end
        br_b = 4'b0001; run_cycle();
        n_chk++;
        if (o_cnt[1] !== 5'd1) begin n_fail++; $display("FAIL lane_stall_drop got=%0d exp=1", o_cnt[1]); end
    endtask

    task automatic test_mid_reset();
        fv1[1] = 4'b0100; fi1[1][2] = 4'd15;
        fv2[1] = 4'b1000; fi2[1][3] = 4'd2;
        step_phase(0);
        step_phase(1);
        rst_s[1] = 1;
        step_phase(2);
        rst_s[1] = 0;
        n_chk++;
        if (o_cnt[1] !== 5'd15 || o_stall[1] !== 1'b0 || o_chk[1][0] !== 4'd1 || o_chk[1][3] !== 4'd4) begin
            n_fail++; $display("FAIL mid_reset_now count=%0d stall=%b chk0=%0d chk3=%0d exp 15/0/1/4",
                               o_cnt[1], o_stall[1], o_chk[1][0], o_chk[1][3]);
        end
        step_phase(3);
        step_phase(4);
        n_chk++;
        if (o_err[1] !== 1'b0) begin n_fail++; $display("FAIL mid_reset_discard err=%b exp=0", o_err[1]); end
        n_chk++;
        if (o_cnt[1] !== 5'd15 || o_chk[1][0] !== 4'd1) begin
            n_fail++; $display("FAIL mid_reset_publish count=%0d chk0=%0d exp 15/1", o_cnt[1], o_chk[1][0]);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        ph4        = 5'b00000;
        rst_s[0]   = 1;
        rst_s[1]   = 1;
        alloc_idle = 0;
        br_idle    = '0;
        clear_requests();
        test_reset();
        test_group_fill();
        test_free_pair_hold();
        test_alloc_free_same();
        test_both_same_index();
        test_dblfree();
        test_random(0, 40);
        test_lane_alloc();
        test_mid_reset();
        test_random(1, 40);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
